mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one four-bank main memory (banked, stall/busy, fixed read latency) between two cache
//  controllers: r0 = I-cache FSM, r1 = D-cache FSM. Round-robin arbitration per request, with
//  bank-conflict fall-through and lock-based ownership so a line fill/writeback is never interleaved.
//  Read data returns tagged to the issuing requester through an owner pipeline.
// PARAMETERS
//  MEM_LAT   2   cycles from read-accept edge to m_data_out valid (>=1)
//  BANK_LSB  1   addr bit position of the 2-bit bank select (bank = addr[BANK_LSB+1:BANK_LSB])
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst            in   1   reset, asynchronous, active-low
//  r0_req/r1_req  in   1   request valid; held, with fields stable, until rX_gnt
//  r0_wr/r1_wr    in   1   1 = write, 0 = read
//  r0_lock/r1_lock in  1   hold ownership after this grant (burst fill/evict)
//  r0_addr/r1_addr in 16   word address
//  r0_data_in/r1_data_in in 16  write data
//  r0_gnt/r1_gnt  out  1   request accepted by memory this cycle (combinational)
//  r0_rvalid/r1_rvalid out 1  read data valid this cycle
//  r0_data_out/r1_data_out out 16  = m_data_out (valid only with rX_rvalid)
//  r0_err/r1_err  out  1   m_err in the cycle of rX_gnt
//  fm_addr,fm_data_in out 16  to memory (muxed from granted requester, else 0)
//  fm_rd,fm_wr    out  1   one-hot-or-zero memory strobe
//  m_data_out     in   16  memory read data
//  m_stall        in   1   memory refuses any request this cycle
//  m_busy         in   4   per-bank busy
//  m_err          in   1   memory error for presented request
// BEHAVIOUR
//  - States: IDLE, OWN0, OWN1. Reset (rst=0, async): state=IDLE, rr_ptr=0, owner pipe cleared;
//    all outputs 0 while rst=0; in-flight reads discarded, no rvalid after reset release.
//  - Eligible(x): rX_req & !m_stall & !m_busy[bank(rX_addr)].
//  - IDLE: preferred = rr_ptr (0 -> r0). Grant preferred if eligible; else grant other if eligible
//    (fall-through). Single requester: grant if eligible. Never both gnt in one cycle.
//  - On grant to x: rr_ptr <= ~x; if rX_lock, state <= OWNx.
//  - OWNx: only x may be granted; other side gnt=0 regardless. Exit to IDLE at the edge where
//    rX_lock=0 (a grant to x in that same cycle is still allowed). rr_ptr unchanged in OWNx.
//  - Memory drive: fm_rd = gnt & !wr, fm_wr = gnt & wr; addr/data from granted side, zeros if none.
//  - Owner pipe: MEM_LAT entries {v,id}; stage0 <= {fm_rd, granted id}, shifts every cycle (memory
//    latency fixed, not stalled). rX_rvalid = tail.v & tail.id==x. Back-to-back reads to distinct
//    banks pipeline fully; returns in issue order.
//  - Writes: complete at gnt; no response.
//  - m_err: routed to rX_err only when rX_gnt=1 that cycle; arbiter state advances as for success.
//  - Request dropped without gnt: legal, no effect. Lock asserted without req: ignored in IDLE.
// STRUCTURE
//  - Shared header mem_arb_defs.vh: state encodings (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2), requester
//    ids, bank-select macro.
//  - Sub-module mem_arb_rdpipe: MEM_LAT-deep {valid,id} shift register with async active-low clear.
//  - Top: state register, rr_ptr flop, combinational grant/mux logic.
// TESTING
//  1 After reset both req read, addr 0x0000/0x0002, busy=0 -> r0_gnt cyc0, r1_gnt cyc1;
//    r0_rvalid cyc2, r1_rvalid cyc3 (MEM_LAT=2), data_out = m_data_out.
//  2 Both req, rr_ptr=0, m_busy[bank(r0_addr)]=1 -> r1 granted (fall-through), rr_ptr=0 after.
//  3 r1 lock=1, 4 reads 0x0010..0x0016 with r0_req held -> r1 gets 4 consecutive gnts, r0_gnt=0
//    until edge where r1_lock=0, then r0 granted next cycle.
//  4 m_stall=1 for 3 cycles with both req -> no gnt, fm_rd/fm_wr=0; grants resume after stall.
//  5 Read granted then rst pulsed low mid-latency -> all outputs 0 immediately; no rvalid afterwards.
//  6 r0 write 0x1234 @0x0040 with m_err=1 -> r0_gnt=1, r0_err=1, fm_wr=1, no rvalid.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encodings,
// requester ids, read-return tag and the bank-select helper.
package mem_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam logic REQ_R0 = 1'b0;
  localparam logic REQ_R1 = 1'b1;

  typedef struct packed {
    logic v;
    logic id;
  } rd_tag_t;

  function automatic logic [1:0] bank_of(input logic [15:0] addr, input int lsb);
    return addr[lsb +: 2];
  endfunction

endpackage

// File: rtl/mem_arbiter_rdpipe.sv
// Fixed-latency owner pipeline: tags each accepted read with its requester
// so the returning memory data can be steered to the right cache.
module mem_arbiter_rdpipe
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t in_tag,
  output rd_tag_t out_tag
);

  rd_tag_t pipe [MEM_LAT];

  // NOTE: every stage is reset because the valid bits are control state;
  // a stale valid surviving reset would fake an rvalid after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= in_tag;
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign out_tag = pipe[MEM_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one banked main memory between the I-cache (r0) and D-cache (r1)
// with round-robin preference, bank-conflict fall-through and burst locking.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT  = 2,
  parameter int BANK_LSB = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r0_req,
  input  logic        r0_wr,
  input  logic        r0_lock,
  input  logic [15:0] r0_addr,
  input  logic [15:0] r0_data_in,
  input  logic        r1_req,
  input  logic        r1_wr,
  input  logic        r1_lock,
  input  logic [15:0] r1_addr,
  input  logic [15:0] r1_data_in,
  output logic        r0_gnt,
  output logic        r1_gnt,
  output logic        r0_rvalid,
  output logic        r1_rvalid,
  output logic [15:0] r0_data_out,
  output logic [15:0] r1_data_out,
  output logic        r0_err,
  output logic        r1_err,
  output logic [15:0] fm_addr,
  output logic [15:0] fm_data_in,
  output logic        fm_rd,
  output logic        fm_wr,
  input  logic [15:0] m_data_out,
  input  logic        m_stall,
  input  logic [3:0]  m_busy,
  input  logic        m_err
);

  logic [1:0] state, state_nx;
  logic       rr_ptr, rr_nx;
  logic       elig0, elig1;
  logic       gnt0_raw, gnt1_raw;
  logic       gnt0, gnt1;
  rd_tag_t    issue_tag, ret_tag;

  assign elig0 = r0_req & ~m_stall & ~m_busy[bank_of(r0_addr, BANK_LSB)];
  assign elig1 = r1_req & ~m_stall & ~m_busy[bank_of(r1_addr, BANK_LSB)];

  // NOTE: defaults first so no path through the case leaves a signal
  // unassigned and infers a latch.
  always_comb begin
    gnt0_raw = 1'b0;
    gnt1_raw = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rr_ptr == REQ_R0) begin
          gnt0_raw = elig0;
          gnt1_raw = ~elig0 & elig1;
        end else begin
          gnt1_raw = elig1;
          gnt0_raw = ~elig1 & elig0;
        end
      end
      ST_OWN0: gnt0_raw = elig0;
      ST_OWN1: gnt1_raw = elig1;
      default: ;
    endcase
  end

  // Outputs are forced quiet for the whole time reset is held.
  assign gnt0 = gnt0_raw & rst;
  assign gnt1 = gnt1_raw & rst;

  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (gnt0) begin
          rr_nx = REQ_R1;
          if (r0_lock) state_nx = ST_OWN0;
        end else if (gnt1) begin
          rr_nx = REQ_R0;
          if (r1_lock) state_nx = ST_OWN1;
        end
      end
      ST_OWN0: if (!r0_lock) state_nx = ST_IDLE;
      ST_OWN1: if (!r1_lock) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      rr_ptr <= REQ_R0;
    end else begin
      state  <= state_nx;
      rr_ptr <= rr_nx;
    end
  end

  assign r0_gnt = gnt0;
  assign r1_gnt = gnt1;
  assign r0_err = gnt0 & m_err;
  assign r1_err = gnt1 & m_err;

  assign fm_rd      = (gnt0 & ~r0_wr) | (gnt1 & ~r1_wr);
  assign fm_wr      = (gnt0 &  r0_wr) | (gnt1 &  r1_wr);
  assign fm_addr    = gnt0 ? r0_addr    : (gnt1 ? r1_addr    : 16'h0000);
  assign fm_data_in = gnt0 ? r0_data_in : (gnt1 ? r1_data_in : 16'h0000);

  assign issue_tag.v  = fm_rd;
  assign issue_tag.id = gnt1 ? REQ_R1 : REQ_R0;

  mem_arbiter_rdpipe #(.MEM_LAT(MEM_LAT)) u_rdpipe (
    .clk     (clk),
    .rst     (rst),
    .in_tag  (issue_tag),
    .out_tag (ret_tag)
  );

  assign r0_rvalid   = ret_tag.v & (ret_tag.id == REQ_R0);
  assign r1_rvalid   = ret_tag.v & (ret_tag.id == REQ_R1);
  assign r0_data_out = rst ? m_data_out : 16'h0000;
  assign r1_data_out = rst ? m_data_out : 16'h0000;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model (owner/round-robin
// rules plus a queue of pending read returns) is compared every cycle.
module tb_mem_arbiter;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r0_req = 0, r0_wr = 0, r0_lock = 0;
  logic [15:0] r0_addr = 0, r0_data_in = 0;
  logic        r1_req = 0, r1_wr = 0, r1_lock = 0;
  logic [15:0] r1_addr = 0, r1_data_in = 0;
  logic        r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err;
  logic [15:0] r0_data_out, r1_data_out, fm_addr, fm_data_in;
  logic        fm_rd, fm_wr;
  logic [15:0] m_data_out = 0;
  logic        m_stall = 0;
  logic [3:0]  m_busy = 0;
  logic        m_err = 0;

  int n_checks = 0;
  int n_pass   = 0;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .BANK_LSB(1)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_wr(r0_wr), .r0_lock(r0_lock), .r0_addr(r0_addr), .r0_data_in(r0_data_in),
    .r1_req(r1_req), .r1_wr(r1_wr), .r1_lock(r1_lock), .r1_addr(r1_addr), .r1_data_in(r1_data_in),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .r0_data_out(r0_data_out), .r1_data_out(r1_data_out), .r0_err(r0_err), .r1_err(r1_err),
    .fm_addr(fm_addr), .fm_data_in(fm_data_in), .fm_rd(fm_rd), .fm_wr(fm_wr),
    .m_data_out(m_data_out), .m_stall(m_stall), .m_busy(m_busy), .m_err(m_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int id;
    int due;
  } rd_t;

  rd_t q[$];
  int  owner = -1;
  bit  rr    = 0;
  int  cyc   = 0;
  int  exp_g = -1;

  function automatic bit wr_of(input int i);
    return (i == 1) ? r1_wr : r0_wr;
  endfunction

  function automatic bit lock_of(input int i);
    return (i == 1) ? r1_lock : r0_lock;
  endfunction

  always @(negedge clk) begin
    bit          el [2];
    int          g;
    bit          rv0, rv1;
    logic [15:0] ea, ed;
    g     = -1;
    el[0] = r0_req && !m_stall && !m_busy[r0_addr[2:1]];
    el[1] = r1_req && !m_stall && !m_busy[r1_addr[2:1]];
    if (rst) begin
      if (owner < 0) begin
        if (el[rr]) g = int'(rr);
        else if (el[1-int'(rr)]) g = 1 - int'(rr);
      end else if (el[owner]) begin
        g = owner;
      end
    end
    exp_g = g;
    rv0 = rst && q.size() > 0 && q[0].due == cyc && q[0].id == 0;
    rv1 = rst && q.size() > 0 && q[0].due == cyc && q[0].id == 1;
    ea  = (g == 0) ? r0_addr    : (g == 1) ? r1_addr    : 16'h0000;
    ed  = (g == 0) ? r0_data_in : (g == 1) ? r1_data_in : 16'h0000;
    check("m_r0_gnt", {15'd0, r0_gnt}, {15'd0, g == 0});
    check("m_r1_gnt", {15'd0, r1_gnt}, {15'd0, g == 1});
    check("m_fm_rd", {15'd0, fm_rd}, {15'd0, g >= 0 && !wr_of(g)});
    check("m_fm_wr", {15'd0, fm_wr}, {15'd0, g >= 0 && wr_of(g)});
    check("m_fm_addr", fm_addr, ea);
    check("m_fm_data_in", fm_data_in, ed);
    check("m_r0_err", {15'd0, r0_err}, {15'd0, g == 0 && m_err});
    check("m_r1_err", {15'd0, r1_err}, {15'd0, g == 1 && m_err});
    check("m_r0_rvalid", {15'd0, r0_rvalid}, {15'd0, rv0});
    check("m_r1_rvalid", {15'd0, r1_rvalid}, {15'd0, rv1});
    if (rv0) check("m_r0_data_out", r0_data_out, m_data_out);
    if (rv1) check("m_r1_data_out", r1_data_out, m_data_out);
    if (!rst) begin
      check("m_rst_r0_data_out", r0_data_out, 16'h0000);
      check("m_rst_r1_data_out", r1_data_out, 16'h0000);
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner <= -1;
      rr    <= 1'b0;
      cyc   <= 0;
      q.delete();
    end else begin
      if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
      if (exp_g >= 0 && !wr_of(exp_g)) q.push_back('{exp_g, cyc + MEM_LAT});
      if (owner < 0) begin
        if (exp_g >= 0) begin
          rr <= (exp_g == 0);
          if (lock_of(exp_g)) owner <= exp_g;
        end
      end else if (!lock_of(owner)) begin
        owner <= -1;
      end
      cyc <= cyc + 1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic q0, input logic w0, input logic l0,
                       input logic [15:0] a0, input logic [15:0] d0,
                       input logic q1, input logic w1, input logic l1,
                       input logic [15:0] a1, input logic [15:0] d1,
                       input logic stall, input logic [3:0] busy,
                       input logic err, input logic [15:0] md);
    @(posedge clk);
    #1;
    r0_req = q0; r0_wr = w0; r0_lock = l0; r0_addr = a0; r0_data_in = d0;
    r1_req = q1; r1_wr = w1; r1_lock = l1; r1_addr = a1; r1_data_in = d1;
    m_stall = stall; m_busy = busy; m_err = err; m_data_out = md;
  endtask

  task automatic idle(input logic [15:0] md);
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0, 4'h0, 0, md);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with requests present: everything stays quiet.
    r0_req = 1; r0_addr = 16'h0000; r1_req = 1; r1_addr = 16'h0002; m_data_out = 16'h7777;
    #3;
    check("rst_r0_gnt", {15'd0, r0_gnt}, 16'd0);
    check("rst_fm_rd", {15'd0, fm_rd}, 16'd0);
    check("rst_r0_data_out", r0_data_out, 16'h0000);

    // Test 1: two reads, round robin from r0.
    @(posedge clk); #1; rst = 1;
    #2; check("t1_r0_gnt", {15'd0, r0_gnt}, 16'd1); check("t1_c0_r1_gnt", {15'd0, r1_gnt}, 16'd0);
    check("t1_c0_fm_addr", fm_addr, 16'h0000);
    drive(0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0002, 0, 0, 4'h0, 0, 16'h0);
    #2; check("t1_r1_gnt", {15'd0, r1_gnt}, 16'd1); check("t1_c1_fm_addr", fm_addr, 16'h0002);
    idle(16'hA5A5);
    #2; check("t1_r0_rvalid", {15'd0, r0_rvalid}, 16'd1); check("t1_r0_data", r0_data_out, 16'hA5A5);
    idle(16'h5A5A);
    #2; check("t1_r1_rvalid", {15'd0, r1_rvalid}, 16'd1); check("t1_r1_data", r1_data_out, 16'h5A5A);
    check("t1_c3_r0_rvalid", {15'd0, r0_rvalid}, 16'd0);

    // Test 2: r0 bank busy -> r1 falls through, pointer stays on r0.
    drive(1, 0, 0, 16'h0004, 0, 1, 0, 0, 16'h0006, 0, 0, 4'b0100, 0, 16'h0);
    #2; check("t2_r1_gnt", {15'd0, r1_gnt}, 16'd1); check("t2_r0_gnt", {15'd0, r0_gnt}, 16'd0);
    drive(1, 0, 0, 16'h0004, 0, 1, 0, 0, 16'h0008, 0, 0, 4'h0, 0, 16'h0);
    #2; check("t2_rr_r0_gnt", {15'd0, r0_gnt}, 16'd1); check("t2_rr_r1_gnt", {15'd0, r1_gnt}, 16'd0);

    // Test 3: r1 locked burst of four reads while r0 waits.
    drive(1, 0, 0, 16'h0020, 0, 1, 0, 1, 16'h0010, 0, 0, 4'h0, 0, 16'h1111);
    #2; check("t3_b0_r1_gnt", {15'd0, r1_gnt}, 16'd1); check("t3_b0_r0_gnt", {15'd0, r0_gnt}, 16'd0);
    drive(1, 0, 0, 16'h0020, 0, 1, 0, 1, 16'h0012, 0, 0, 4'h0, 0, 16'h2222);
    #2; check("t3_b1_r1_gnt", {15'd0, r1_gnt}, 16'd1); check("t3_b1_r0_gnt", {15'd0, r0_gnt}, 16'd0);
    drive(1, 0, 0, 16'h0020, 0, 1, 0, 1, 16'h0014, 0, 0, 4'h0, 0, 16'h3333);
    #2; check("t3_b2_r1_gnt", {15'd0, r1_gnt}, 16'd1); check("t3_b2_r0_gnt", {15'd0, r0_gnt}, 16'd0);
    drive(1, 0, 0, 16'h0020, 0, 1, 0, 0, 16'h0016, 0, 0, 4'h0, 0, 16'h4444);
    #2; check("t3_b3_r1_gnt", {15'd0, r1_gnt}, 16'd1); check("t3_b3_r0_gnt", {15'd0, r0_gnt}, 16'd0);
    drive(1, 0, 0, 16'h0020, 0, 0, 0, 0, 16'h0000, 0, 0, 4'h0, 0, 16'h5555);
    #2; check("t3_after_r0_gnt", {15'd0, r0_gnt}, 16'd1);

    // Test 4: three stall cycles, then r1 (preferred) write goes first.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 16'h0030, 0, 1, 1, 0, 16'h0032, 16'hBEEF, 1, 4'h0, 0, 16'h6666);
      #2; check("t4_stall_gnt", {14'd0, r1_gnt, r0_gnt}, 16'd0);
      check("t4_stall_strobe", {14'd0, fm_wr, fm_rd}, 16'd0);
    end
    drive(1, 0, 0, 16'h0030, 0, 1, 1, 0, 16'h0032, 16'hBEEF, 0, 4'h0, 0, 16'h0);
    #2; check("t4_r1_gnt", {15'd0, r1_gnt}, 16'd1); check("t4_fm_wr", {15'd0, fm_wr}, 16'd1);
    check("t4_fm_data_in", fm_data_in, 16'hBEEF); check("t4_fm_addr", fm_addr, 16'h0032);
    drive(1, 0, 0, 16'h0030, 0, 0, 0, 0, 16'h0000, 0, 0, 4'h0, 0, 16'h0);
    #2; check("t4_r0_gnt", {15'd0, r0_gnt}, 16'd1);

    // Test 6: write with memory error.
    drive(1, 1, 0, 16'h0040, 16'h1234, 0, 0, 0, 16'h0000, 0, 0, 4'h0, 1, 16'h0);
    #2; check("t6_r0_gnt", {15'd0, r0_gnt}, 16'd1); check("t6_r0_err", {15'd0, r0_err}, 16'd1);
    check("t6_fm_wr", {15'd0, fm_wr}, 16'd1); check("t6_fm_data_in", fm_data_in, 16'h1234);
    idle(16'h9999);
    idle(16'h8888);
    #2; check("t6_no_rvalid", {14'd0, r1_rvalid, r0_rvalid}, 16'd0);

    // Test 5: reset pulse while a read is in flight.
    drive(0, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0050, 0, 0, 4'h0, 0, 16'h0);
    #2; check("t5_r1_gnt", {15'd0, r1_gnt}, 16'd1);
    drive(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 4'h0, 0, 16'hCAFE);
    rst = 0;
    #1; check("t5_rst_r0_gnt", {15'd0, r0_gnt}, 16'd0); check("t5_rst_fm_rd", {15'd0, fm_rd}, 16'd0);
    check("t5_rst_r1_data_out", r1_data_out, 16'h0000);
    drive(1, 0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 0, 0, 4'h0, 0, 16'hCAFE);
    #2; check("t5_rst_r1_rvalid", {15'd0, r1_rvalid}, 16'd0);
    idle(16'hCAFE);
    rst = 1;
    #2; check("t5_post_r1_rvalid", {15'd0, r1_rvalid}, 16'd0);
    drive(1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0002, 0, 0, 4'h0, 0, 16'h0);
    #2; check("t5_post_r0_gnt", {15'd0, r0_gnt}, 16'd1);
    idle(16'h0);
    idle(16'h0);
    idle(16'h0);
    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
